mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 16 +
 rtl/mem_port_arbiter.sv | 78 +++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester-side memory port: request/grant handshake plus read return.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port memory: m0 has priority, m1 is
// guaranteed a grant after STARVE_MAX consecutive contested m0 wins.
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave m0,
  mem_port_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_q, starve_d;
  logic              tag_vld_q, tag_vld_d;
  logic              tag_own_q, tag_own_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic g0, g1, contested, win_we, rv0, rv1;

  // Grants are masked by reset so nothing reaches memory while rst_n is low.
  always_comb begin
    contested = m0.req & m1.req;
    g1        = rst_n & m1.req & (~m0.req | (starve_q == STARVE_LIM));
    g0        = rst_n & m0.req & ~g1;
    win_we    = g1 ? m1.we : m0.we;

    m0.gnt    = g0;
    m1.gnt    = g1;
    mem_we    = (g0 | g1) & win_we;
    mem_re    = (g0 | g1) & ~win_we;
    mem_addr  = g1 ? m1.addr  : (g0 ? m0.addr  : '0);
    mem_wdata = g1 ? m1.wdata : (g0 ? m0.wdata : '0);
  end

  always_comb begin
    starve_d = starve_q;
    if (g1)                  starve_d = 4'd0;
    else if (g0 & contested) starve_d = starve_q + 4'd1;
    tag_vld_d = (g0 | g1) & ~win_we;
    tag_own_d = g1;
  end

  // Return data passes straight through in the return cycle and is held after.
  always_comb begin
    rv0       = tag_vld_q & ~tag_own_q;
    rv1       = tag_vld_q & tag_own_q;
    m0.rvalid = rv0;
    m1.rvalid = rv1;
    m0.rdata  = rv0 ? mem_rdata : rdata0_q;
    m1.rdata  = rv1 ? mem_rdata : rdata1_q;
    rdata0_d  = m0.rdata;
    rdata1_d  = m1.rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q  <= 4'd0;
      tag_vld_q <= 1'b0;
      tag_own_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      starve_q  <= starve_d;
      tag_vld_q <= tag_vld_d;
      tag_own_q <= tag_own_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a rule-level model.
module tb_mem_port_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_re;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) m0_if ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) m1_if ();

  mem_port_arbiter #(.STARVE_MAX(SMAX), .ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [7:0] a);
    return {4{a}} ^ 32'hC3C3_0F0F;
  endfunction

  // Memory device: one-cycle read latency, junk on mem_rdata when not reading.
  logic [31:0]  mem_arr [256];
  logic [255:0] wvld = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem_arr[mem_addr] <= mem_wdata;
      wvld[mem_addr]    <= 1'b1;
    end
    mem_rdata <= mem_re ? (wvld[mem_addr] ? mem_arr[mem_addr] : dflt(mem_addr)) : $urandom;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stimulus state
  bit r0, w0, r1, w1;
  logic [7:0]  a0, a1;
  logic [31:0] d0, d1;
  bit pend0, pend1;

  // Reference model state
  int          cnt;
  bit          ret_v, ret_own;
  logic [31:0] ret_data, last0, last1;
  logic [31:0] shadow [int];
  int          gcode;

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return dflt(a);
  endfunction

  task automatic step();
    bit eg0, eg1, ewe;
    logic [7:0]  ea;
    logic [31:0] ed, er0, er1;
    @(negedge clk);
    m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
    #1;
    eg1 = r1 && (!r0 || cnt == SMAX);
    eg0 = r0 && !eg1;
    ewe = eg1 ? w1 : w0;
    ea  = eg1 ? a1 : (eg0 ? a0 : 8'h0);
    ed  = eg1 ? d1 : (eg0 ? d0 : 32'h0);
    chk("m0_gnt", m0_if.gnt, eg0);
    chk("m1_gnt", m1_if.gnt, eg1);
    chk("mem_we", mem_we, (eg0 || eg1) && ewe);
    chk("mem_re", mem_re, (eg0 || eg1) && !ewe);
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ed);
    er0 = (ret_v && !ret_own) ? ret_data : last0;
    er1 = (ret_v &&  ret_own) ? ret_data : last1;
    chk("m0_rvalid", m0_if.rvalid, ret_v && !ret_own);
    chk("m1_rvalid", m1_if.rvalid, ret_v && ret_own);
    chk("m0_rdata", m0_if.rdata, er0);
    chk("m1_rdata", m1_if.rdata, er1);
    last0 = er0; last1 = er1;
    if (eg1) cnt = 0;
    else if (eg0 && r1) cnt++;
    ret_v    = (eg0 || eg1) && !ewe;
    ret_own  = eg1;
    ret_data = model_read(ea);
    if ((eg0 || eg1) && ewe) shadow[int'(ea)] = ed;
    pend0 = r0 && !eg0;
    pend1 = r1 && !eg1;
    gcode = eg1 ? 2 : (eg0 ? 1 : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_m0_rvalid", m0_if.rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_if.rvalid, 1'b0);
    chk("rst_m0_rdata", m0_if.rdata, 32'h0);
    chk("rst_m1_rdata", m1_if.rdata, 32'h0);
    m0_if.req = 1'b1; m0_if.we = 1'b0; m1_if.req = 1'b1; m1_if.we = 1'b0;
    #1;
    chk("rst_m0_gnt", m0_if.gnt, 1'b0);
    chk("rst_m1_gnt", m1_if.gnt, 1'b0);
    chk("rst_mem_re", mem_re, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    @(negedge clk);
    m0_if.req = 1'b0; m1_if.req = 1'b0;
    r0 = 0; r1 = 0; pend0 = 0; pend1 = 0;
    cnt = 0; ret_v = 0; last0 = '0; last1 = '0;
    rst_n = 1'b1;
  endtask

  task automatic contest(input int n, output logic [15:0] seq);
    seq = '0;
    for (int i = 0; i < n; i++) begin
      r0 = 1; w0 = 0; a0 = 8'(i); r1 = 1; w1 = 0; a1 = 8'(i + 8'h40);
      step();
      seq[i] = (gcode == 2);
    end
  endtask

  logic [15:0] seq;

  initial begin
    rst_n = 1'b0;
    r0 = 0; w0 = 0; a0 = '0; d0 = '0; r1 = 0; w1 = 0; a1 = '0; d1 = '0;
    m0_if.req = 0; m0_if.we = 0; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.addr = '0; m1_if.wdata = '0;
    cnt = 0; ret_v = 0; ret_own = 0; ret_data = '0; last0 = '0; last1 = '0;
    do_reset();

    // m1 write alone
    r1 = 1; w1 = 1; a1 = 8'h20; d1 = 32'h1234_5678; step(); r1 = 0;
    step();
    // m0 read of a freshly written location
    r1 = 1; w1 = 1; a1 = 8'h10; d1 = 32'hDEAD_BEEF; step(); r1 = 0;
    r0 = 1; w0 = 0; a0 = 8'h10; step(); r0 = 0;
    step();
    chk("m0_rdata_deadbeef", m0_if.rdata, 32'hDEAD_BEEF);
    // back-to-back reads, different owners
    r0 = 1; w0 = 0; a0 = 8'h04; step(); r0 = 0;
    r1 = 1; w1 = 0; a1 = 8'h08; step(); r1 = 0;
    step();

    do_reset();
    contest(10, seq);
    chk("starve_seq", seq, 16'h0210);

    // reset with an m0 read in flight, then starvation counter restarts
    contest(2, seq);
    r1 = 0; r0 = 1; w0 = 0; a0 = 8'h33; step(); r0 = 0;
    do_reset();
    step();
    contest(5, seq);
    chk("starve_after_rst", seq, 16'h0010);

    // m1 withdraws while m0 busy
    do_reset();
    r0 = 1; w0 = 0; a0 = 8'h01; r1 = 1; w1 = 1; a1 = 8'h77; d1 = 32'hCAFE; step();
    r1 = 0;
    for (int i = 0; i < 4; i++) begin a0 = 8'(i + 2); step(); end
    r0 = 0;
    contest(4, seq);
    chk("starve_after_withdraw", seq, 16'h0008);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (pend0) begin
        if ($urandom_range(0, 15) == 0) r0 = 0;
      end else begin
        r0 = ($urandom_range(0, 9) < 6); w0 = $urandom_range(0, 1);
        a0 = 8'($urandom); d0 = $urandom;
      end
      if (pend1) begin
        if ($urandom_range(0, 7) == 0) r1 = 0;
      end else begin
        r1 = ($urandom_range(0, 9) < 6); w1 = $urandom_range(0, 1);
        a1 = 8'($urandom); d1 = $urandom;
      end
      if (c == 1500) do_reset();
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
